egress_tid_arbiter: RTL and testbench

// - Packet-granular round-robin arbiter merging NUM_AXIS_ID per-tenant egress AXI streams into one stream.
// - Tags each output beat's tid with the index of the granted source input.
// - Feeds the pre-MAC interface stage, which attaches the route mask; sits directly upstream of it.
// - Never interleaves beats of different packets; output is registered through a skid buffer.

---
 rtl/nmu_axis_pkg.sv | 37 +++
 rtl/axis_skid_buffer.sv | 64 ++++++
 rtl/egress_tid_arbiter.sv | 132 +++++++++++++
 tb/tb_egress_tid_arbiter.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nmu_axis_pkg.sv
// Shared AXI-stream helpers for the NMU egress path: arbiter state type and
// the rotating-priority pick used by packet arbiters.
package nmu_axis_pkg;

   typedef enum logic {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } arb_state_t;

   // Widest requester vector rr_pick can scan (AXIS_ID_WIDTH up to 6).
   localparam int RR_MAX_N = 64;
   localparam int RR_IDX_W = 6;

   // First asserted req after 'last', scanning last+1, last+2, ... modulo n.
   // Returns 'last' unchanged when nothing is requesting.
   function automatic logic [RR_IDX_W-1:0] rr_pick(
      input logic [RR_MAX_N-1:0] req,
      input logic [RR_IDX_W-1:0] last,
      input int unsigned         n
   );
      logic [RR_IDX_W-1:0] pick;
      logic                found;
      int unsigned         idx;
      pick  = last;
      found = 1'b0;
      for (int unsigned k = 1; k <= RR_MAX_N; k++) begin
         idx = int'(last) + k;
         if (idx >= n) idx = idx - n;
         if (!found && (k <= n) && req[idx[RR_IDX_W-1:0]]) begin
            pick  = idx[RR_IDX_W-1:0];
            found = 1'b1;
         end
      end
      return pick;
   endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry register slice: registered input ready, one-cycle accept-to-valid
// latency and full throughput while the output is ready.
module axis_skid_buffer #(
   parameter int WIDTH = 8
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic [WIDTH-1:0] in_data_i,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   output logic [WIDTH-1:0] out_data_o,
   output logic             out_valid_o,
   input  logic             out_ready_i
);

   logic [WIDTH-1:0] mem_q [2];
   logic             wr_ptr_q;
   logic             rd_ptr_q;
   logic [1:0]       count_q;
   logic [1:0]       count_d;
   logic             in_ready_q;
   logic             push;
   logic             pop;

   assign push = in_valid_i & in_ready_q;
   assign pop  = (count_q != 2'd0) & out_ready_i;

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path infers a latch.
      count_d = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + 2'd1;
         2'b01:   count_d = count_q - 2'd1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_i) begin
      // NOTE: clocked state uses non-blocking assignments only, so every register sees pre-edge values.
      if (!rst_ni) begin
         // NOTE: the two storage entries are reset as well so the output payload reads zero out of reset.
         mem_q[0]   <= '0;
         mem_q[1]   <= '0;
         wr_ptr_q   <= 1'b0;
         rd_ptr_q   <= 1'b0;
         count_q    <= 2'd0;
         in_ready_q <= 1'b1;
      end else begin
         if (push) begin
            mem_q[wr_ptr_q] <= in_data_i;
            wr_ptr_q        <= ~wr_ptr_q;
         end
         if (pop) rd_ptr_q <= ~rd_ptr_q;
         count_q    <= count_d;
         // Ready is a register of next occupancy, so it never sees out_ready_i combinationally.
         in_ready_q <= (count_d != 2'd2);
      end
   end

   assign in_ready_o  = in_ready_q;
   assign out_valid_o = (count_q != 2'd0);
   assign out_data_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/egress_tid_arbiter.sv
// Packet-granular round-robin merge of NUM_AXIS_ID egress streams into one,
// tagging tid with the granted input; output goes through a 2-entry slice.
module egress_tid_arbiter
   import nmu_axis_pkg::*;
#(
   parameter  int AXIS_BUS_WIDTH  = 64,
   parameter  int AXIS_ID_WIDTH   = 4,
   parameter  int AXIS_DEST_WIDTH = 0,
   localparam int NUM_AXIS_ID     = 2**AXIS_ID_WIDTH,
   localparam int ID_W            = (AXIS_ID_WIDTH > 0) ? AXIS_ID_WIDTH : 1,
   localparam int DEST_W          = (AXIS_DEST_WIDTH > 0) ? AXIS_DEST_WIDTH : 1,
   localparam int KEEP_W          = AXIS_BUS_WIDTH / 8
) (
   input  logic                                aclk,
   input  logic                                aresetn,
   input  logic [NUM_AXIS_ID*AXIS_BUS_WIDTH-1:0] axis_in_tdata,
   input  logic [NUM_AXIS_ID*DEST_W-1:0]       axis_in_tdest,
   input  logic [NUM_AXIS_ID*KEEP_W-1:0]       axis_in_tkeep,
   input  logic [NUM_AXIS_ID-1:0]              axis_in_tlast,
   input  logic [NUM_AXIS_ID-1:0]              axis_in_tvalid,
   output logic [NUM_AXIS_ID-1:0]              axis_in_tready,
   output logic [AXIS_BUS_WIDTH-1:0]           axis_out_tdata,
   output logic [ID_W-1:0]                     axis_out_tid,
   output logic [DEST_W-1:0]                   axis_out_tdest,
   output logic [KEEP_W-1:0]                   axis_out_tkeep,
   output logic                                axis_out_tlast,
   output logic                                axis_out_tvalid,
   input  logic                                axis_out_tready
);

   localparam int PAYLOAD_W = AXIS_BUS_WIDTH + KEEP_W + 1 + ID_W + DEST_W;

   arb_state_t                state_q, state_d;
   logic [ID_W-1:0]           grant_q, grant_d;
   logic [ID_W-1:0]           last_grant_q, last_grant_d;
   logic [RR_MAX_N-1:0]       req_ext;
   logic [ID_W-1:0]           rr_next;

   logic [AXIS_BUS_WIDTH-1:0] sel_data;
   logic [KEEP_W-1:0]         sel_keep;
   logic [DEST_W-1:0]         sel_dest;
   logic                      sel_last;
   logic                      sel_valid;

   logic                      skid_in_valid;
   logic                      skid_in_ready;
   logic                      beat_accept;
   logic [PAYLOAD_W-1:0]      skid_in_data;
   logic [PAYLOAD_W-1:0]      skid_out_data;

   always_comb begin
      req_ext                    = '0;
      req_ext[NUM_AXIS_ID-1:0]   = axis_in_tvalid;
   end

   assign rr_next = ID_W'(rr_pick(req_ext, RR_IDX_W'(last_grant_q), NUM_AXIS_ID));

   // Input mux follows the held grant, not the live requests.
   assign sel_data  = axis_in_tdata[int'(grant_q)*AXIS_BUS_WIDTH +: AXIS_BUS_WIDTH];
   assign sel_keep  = axis_in_tkeep[int'(grant_q)*KEEP_W +: KEEP_W];
   assign sel_last  = axis_in_tlast[grant_q];
   assign sel_valid = axis_in_tvalid[grant_q];

   generate
      if (AXIS_DEST_WIDTH == 0) begin : g_no_dest
         logic unused_dest;
         assign unused_dest = ^axis_in_tdest;
         assign sel_dest    = '0;
      end else begin : g_dest
         assign sel_dest = axis_in_tdest[int'(grant_q)*DEST_W +: DEST_W];
      end
   endgenerate

   assign skid_in_valid = (state_q == LOCKED) & sel_valid;
   assign beat_accept   = skid_in_valid & skid_in_ready;
   assign skid_in_data  = {sel_data, sel_keep, sel_last, grant_q, sel_dest};

   always_comb begin
      axis_in_tready = '0;
      if (state_q == LOCKED) axis_in_tready[grant_q] = skid_in_ready;
   end

   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      case (state_q)
         IDLE: begin
            if (|axis_in_tvalid) begin
               grant_d = rr_next;
               state_d = LOCKED;
            end
         end
         LOCKED: begin
            // A tvalid gap keeps the grant; only an accepted tlast releases it.
            if (beat_accept && sel_last) begin
               last_grant_d = grant_q;
               state_d      = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         state_q      <= IDLE;
         grant_q      <= '0;
         last_grant_q <= ID_W'(NUM_AXIS_ID - 1);
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
      end
   end

   axis_skid_buffer #(
      .WIDTH (PAYLOAD_W)
   ) u_skid (
      .clk_i       (aclk),
      .rst_ni      (aresetn),
      .in_data_i   (skid_in_data),
      .in_valid_i  (skid_in_valid),
      .in_ready_o  (skid_in_ready),
      .out_data_o  (skid_out_data),
      .out_valid_o (axis_out_tvalid),
      .out_ready_i (axis_out_tready)
   );

   assign {axis_out_tdata, axis_out_tkeep, axis_out_tlast, axis_out_tid, axis_out_tdest} = skid_out_data;

endmodule

// File: tb/tb_egress_tid_arbiter.sv
// Bench for egress_tid_arbiter: per-source packet queues drive the inputs, a
// scoreboard checks every output beat against what each source sent.
module tb_egress_tid_arbiter;

   localparam int BUS = 64;
   localparam int KW  = BUS / 8;
   localparam int N   = 16;

   typedef struct {
      logic [BUS-1:0] data;
      logic [KW-1:0]  keep;
      logic           last;
      int             gap;
   } beat_t;

   logic             aclk = 1'b0;
   logic             aresetn;
   logic [N*BUS-1:0] in_tdata;
   logic [N-1:0]     in_tdest;
   logic [N*KW-1:0]  in_tkeep;
   logic [N-1:0]     in_tlast;
   logic [N-1:0]     in_tvalid;
   logic [N-1:0]     in_tready;
   logic [BUS-1:0]   out_tdata;
   logic [3:0]       out_tid;
   logic [0:0]       out_tdest;
   logic [KW-1:0]    out_tkeep;
   logic             out_tlast;
   logic             out_tvalid;
   logic             out_tready;

   beat_t      src_q [N][$];
   beat_t      exp_q [N][$];
   int         tid_log[$];
   int         exp_tids[$];
   int         tests = 0;
   int         fails = 0;
   int         rdy_mode = 0;
   int         cyc = 0;
   int         beat_cnt = 0;
   bit         mon_en = 1'b1;

   always #5 aclk = ~aclk;

   egress_tid_arbiter #(
      .AXIS_BUS_WIDTH  (BUS),
      .AXIS_ID_WIDTH   (4),
      .AXIS_DEST_WIDTH (0)
   ) dut (
      .aclk            (aclk),
      .aresetn         (aresetn),
      .axis_in_tdata   (in_tdata),
      .axis_in_tdest   (in_tdest),
      .axis_in_tkeep   (in_tkeep),
      .axis_in_tlast   (in_tlast),
      .axis_in_tvalid  (in_tvalid),
      .axis_in_tready  (in_tready),
      .axis_out_tdata  (out_tdata),
      .axis_out_tid    (out_tid),
      .axis_out_tdest  (out_tdest),
      .axis_out_tkeep  (out_tkeep),
      .axis_out_tlast  (out_tlast),
      .axis_out_tvalid (out_tvalid),
      .axis_out_tready (out_tready)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push_pkt(input int src, input int len, input int gap_at, input int gap_len,
                           input logic [KW-1:0] last_keep);
      beat_t b;
      for (int k = 0; k < len; k++) begin
         b.data = {$urandom, $urandom};
         b.keep = (k == len - 1) ? last_keep : 8'hFF;
         b.last = (k == len - 1);
         b.gap  = (k == gap_at) ? gap_len : 0;
         src_q[src].push_back(b);
         exp_q[src].push_back(b);
      end
   endtask

   task automatic wait_drain(input string tag, input int budget);
      int n = 0;
      bit busy;
      do begin
         @(negedge aclk);
         busy = out_tvalid;
         for (int i = 0; i < N; i++)
            if (src_q[i].size() != 0 || exp_q[i].size() != 0) busy = 1'b1;
         n++;
      end while (busy && n < budget);
      check({tag, "_drained"}, 64'(busy), 64'd0);
   endtask

   task automatic check_order(input string tag);
      check({tag, "_pkt_count"}, 64'(tid_log.size()), 64'(exp_tids.size()));
      for (int k = 0; k < exp_tids.size(); k++)
         if (k < tid_log.size())
            check($sformatf("%s_tid%0d", tag, k), 64'(tid_log[k]), 64'(exp_tids[k]));
   endtask

   // Source driver and output-ready generator.
   initial begin
      logic [N-1:0] fire;
      in_tvalid  = '0;
      in_tdata   = '0;
      in_tkeep   = '0;
      in_tlast   = '0;
      in_tdest   = '0;
      out_tready = 1'b1;
      forever begin
         @(negedge aclk);
         fire = in_tvalid & in_tready;
         @(posedge aclk);
         #1;
         cyc++;
         case (rdy_mode)
            0:       out_tready = 1'b1;
            1:       out_tready = (cyc % 4 == 0) || (cyc % 4 == 3);
            default: out_tready = ($urandom_range(0, 3) != 0);
         endcase
         for (int i = 0; i < N; i++) begin
            if (fire[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
            in_tvalid[i] = 1'b0;
            if (src_q[i].size() > 0) begin
               if (src_q[i][0].gap > 0) begin
                  src_q[i][0].gap = src_q[i][0].gap - 1;
               end else begin
                  in_tvalid[i]          = 1'b1;
                  in_tdata[i*BUS +: BUS] = src_q[i][0].data;
                  in_tkeep[i*KW +: KW]   = src_q[i][0].keep;
                  in_tlast[i]           = src_q[i][0].last;
               end
            end
         end
      end
   end

   // Output scoreboard: per-source ordering, no interleaving, stall stability.
   initial begin
      bit             in_pkt = 1'b0;
      bit             stall_prev = 1'b0;
      logic [3:0]     cur_tid = '0;
      logic [BUS-1:0] st_data;
      logic [KW-1:0]  st_keep;
      logic           st_last;
      logic [3:0]     st_tid;
      beat_t          e;
      forever begin
         @(negedge aclk);
         if (!mon_en) begin
            in_pkt     = 1'b0;
            stall_prev = 1'b0;
         end else begin
            if (stall_prev) begin
               check("stall_valid_held", 64'(out_tvalid), 64'd1);
               check("stall_data_held", out_tdata, st_data);
               check("stall_keep_held", 64'(out_tkeep), 64'(st_keep));
               check("stall_last_held", 64'(out_tlast), 64'(st_last));
               check("stall_tid_held", 64'(out_tid), 64'(st_tid));
            end
            stall_prev = out_tvalid && !out_tready;
            st_data = out_tdata;
            st_keep = out_tkeep;
            st_last = out_tlast;
            st_tid  = out_tid;
            if (out_tvalid && out_tready) begin
               beat_cnt++;
               if (in_pkt) check("no_interleave", 64'(out_tid), 64'(cur_tid));
               else begin
                  tid_log.push_back(int'(out_tid));
                  cur_tid = out_tid;
               end
               check("tdest_zero", 64'(out_tdest), 64'd0);
               check("beat_was_sent", 64'(exp_q[out_tid].size() > 0), 64'd1);
               if (exp_q[out_tid].size() > 0) begin
                  e = exp_q[out_tid].pop_front();
                  check("beat_data", out_tdata, e.data);
                  check("beat_keep", 64'(out_tkeep), 64'(e.keep));
                  check("beat_last", 64'(out_tlast), 64'(e.last));
               end
               in_pkt = !out_tlast;
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int  b0;
      int  t;
      int  lat;
      int  early4;
      bit  done2;
      bit  got;

      // Reset, then ten idle cycles.
      aresetn = 1'b0;
      repeat (3) @(negedge aclk);
      check("rst_out_tvalid", 64'(out_tvalid), 64'd0);
      check("rst_out_tdata", out_tdata, 64'd0);
      check("rst_out_tkeep", 64'(out_tkeep), 64'd0);
      check("rst_out_tid", 64'(out_tid), 64'd0);
      check("rst_out_tlast", 64'(out_tlast), 64'd0);
      check("rst_in_tready", 64'(in_tready), 64'd0);
      aresetn = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(negedge aclk);
         check($sformatf("idle_tready_c%0d", c), 64'(in_tready), 64'd0);
         check($sformatf("idle_tvalid_c%0d", c), 64'(out_tvalid), 64'd0);
      end

      // Contention: 0, 5, 15 each with two back-to-back 2-beat packets.
      tid_log.delete();
      for (int r = 0; r < 2; r++) begin
         push_pkt(0, 2, -1, 0, 8'hFF);
         push_pkt(5, 2, -1, 0, 8'hFF);
         push_pkt(15, 2, -1, 0, 8'hFF);
      end
      wait_drain("contention", 200);
      exp_tids = '{0, 5, 15, 0, 5, 15};
      check_order("contention");

      // Single source latency and pass-through.
      tid_log.delete();
      b0 = beat_cnt;
      push_pkt(3, 4, -1, 0, 8'h0F);
      t = 0;
      do begin @(negedge aclk); t++; end while (!in_tvalid[3] && t < 20);
      check("single_src_valid_seen", 64'(in_tvalid[3]), 64'd1);
      lat = 0;
      do begin @(negedge aclk); lat++; end while (!out_tvalid && lat < 20);
      check("single_latency", 64'(lat), 64'd2);
      wait_drain("single", 100);
      check("single_beats", 64'(beat_cnt - b0), 64'd4);
      exp_tids = '{3};
      check_order("single");

      // Backpressure 1,0,0,1 on a 16-beat packet.
      tid_log.delete();
      b0 = beat_cnt;
      rdy_mode = 1;
      push_pkt(7, 16, -1, 0, 8'h3F);
      wait_drain("backpressure", 300);
      rdy_mode = 0;
      check("bp_beats", 64'(beat_cnt - b0), 64'd16);
      exp_tids = '{7};
      check_order("backpressure");

      // Gap hold: input 2 goes quiet mid-packet while input 4 requests.
      tid_log.delete();
      push_pkt(2, 6, 3, 5, 8'hFF);
      t = 0;
      do begin @(negedge aclk); t++; end while (!in_tready[2] && t < 20);
      check("gap_grant2", 64'(in_tready[2]), 64'd1);
      push_pkt(4, 3, -1, 0, 8'hFF);
      early4 = 0;
      done2  = 1'b0;
      got    = 1'b0;
      t      = 0;
      do begin
         @(negedge aclk);
         if (in_tready[4]) begin
            if (!done2) early4++;
            got = 1'b1;
         end
         if (in_tvalid[2] && in_tready[2] && in_tlast[2]) done2 = 1'b1;
         t++;
      end while (!got && t < 100);
      check("gap_no_early_tready4", 64'(early4), 64'd0);
      check("gap_tlast2_accepted", 64'(done2), 64'd1);
      check("gap_input4_served", 64'(got), 64'd1);
      wait_drain("gap", 100);
      exp_tids = '{2, 4};
      check_order("gap");

      // Reset in the middle of an 8-beat packet from input 1.
      push_pkt(1, 8, -1, 0, 8'hFF);
      t = 0;
      do begin @(negedge aclk); t++; end while (src_q[1].size() > 5 && t < 50);
      check("mid_rst_three_beats_in", 64'(src_q[1].size()), 64'd5);
      mon_en = 1'b0;
      src_q[1].delete();
      exp_q[1].delete();
      aresetn = 1'b0;
      @(negedge aclk);
      check("mid_rst_out_tvalid", 64'(out_tvalid), 64'd0);
      check("mid_rst_in_tready", 64'(in_tready), 64'd0);
      @(negedge aclk);
      aresetn = 1'b1;
      mon_en  = 1'b1;
      tid_log.delete();
      push_pkt(10, 2, -1, 0, 8'hFF);
      push_pkt(3, 2, -1, 0, 8'hFF);
      wait_drain("post_reset", 100);
      exp_tids = '{3, 10};
      check_order("post_reset");

      // Randomized traffic with random gaps and random downstream ready.
      rdy_mode = 2;
      for (int it = 0; it < 300; it++) begin
         @(negedge aclk);
         if ($urandom_range(0, 3) == 0)
            push_pkt(int'($urandom_range(0, N - 1)), int'($urandom_range(1, 6)),
                     int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
                     8'($urandom_range(1, 255)));
      end
      wait_drain("random", 5000);
      rdy_mode = 0;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
